// File: rtl/a_cfg_pkg.sv
// a_cfg_pkg
// Shared constants for the a-domain configuration loader: command word
// geometry, the opcode map of the d2a/a2d command FIFOs, and the helper
// that assembles a response word from payload and opcode.
package a_cfg_pkg;

    localparam int CMD_W    = 32;
    localparam int OPCODE_W = 15;
    localparam int CMD_PL_W = CMD_W - OPCODE_W;

    localparam logic [OPCODE_W-1:0] OP_WR      = 15'd1;
    localparam logic [OPCODE_W-1:0] OP_ACK     = 15'd2;
    localparam logic [OPCODE_W-1:0] OP_SET_IDX = 15'd3;
    localparam logic [OPCODE_W-1:0] OP_RD      = 15'd4;
    localparam logic [OPCODE_W-1:0] OP_RD_RSP  = 15'd5;
    localparam logic [OPCODE_W-1:0] OP_CLEAR   = 15'd6;

    // Response word layout matches the command layout: payload above opcode.
    function automatic logic [CMD_W-1:0] build_resp(
        input logic [CMD_PL_W-1:0] payload,
        input logic [OPCODE_W-1:0] opcode
    );
        return {payload, opcode};
    endfunction

endpackage

// File: rtl/a_cfg_resp_slot.sv
// a_cfg_resp_slot
// One-entry response buffer in front of the a2d command FIFO.
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset (drops a pending entry)
//   load_i          : write load_data_i into the slot (caller checks can_accept_o)
//   load_data_i     : response word to queue
//   full_i          : a2d FIFO full
//   can_accept_o    : slot empty, or draining this cycle
//   wr_en_o, din_o  : a2d FIFO push strobe and data
module a_cfg_resp_slot
    import a_cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CMD_W-1:0] load_data_i,
    input  logic             full_i,
    output logic             can_accept_o,
    output logic             wr_en_o,
    output logic [CMD_W-1:0] din_o
);

    logic             valid_q, valid_d;
    logic [CMD_W-1:0] data_q, data_d;

    assign wr_en_o      = valid_q & ~full_i;
    assign din_o        = data_q;
    // A drain and a load in the same cycle keep the slot occupied with new data.
    assign can_accept_o = ~valid_q | wr_en_o;

    // Next-state: load has priority over drain so back-to-back responses stream.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = load_data_i;
        end else if (wr_en_o) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/a_config_loader.sv
// a_config_loader
// Pops configuration commands from the d2a command FIFO (first-word-fall-
// through) and keeps NUM_WORDS words of PAYLOAD_W bits. Handles sequential
// write (WR), pointer set (SET_IDX), readback (RD) and CLEAR; ACK and RD_RSP
// responses leave through a one-entry slot into the a2d command FIFO.
// Opcodes not owned here stay at the FIFO head, flagged on cmd_other_valid,
// until an external consumer pops them with cmd_other_take.
// Ports:
//   clk_a_domain, reset        : clock, synchronous active-high reset
//   fifo_d2a_command_*         : command FIFO pop side (rd_en, dout, empty)
//   fifo_a2d_command_*         : response FIFO push side (wr_en, din, full)
//   cmd_other_valid/_take      : hand-off of non-config opcodes
//   cfg_flat                   : word i at [PAYLOAD_W*i +: PAYLOAD_W]
//   cfg_valid, cfg_ptr         : full set loaded, next write index
//   cfg_error                  : sticky protocol error, cleared by CLEAR
module a_config_loader
    import a_cfg_pkg::*;
#(
    parameter int PAYLOAD_W = 17,
    parameter int NUM_WORDS = 39,
    parameter int IDX_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                           clk_a_domain,
    input  logic                           reset,
    output logic                           fifo_d2a_command_rd_en,
    input  logic [CMD_W-1:0]               fifo_d2a_command_dout,
    input  logic                           fifo_d2a_command_empty,
    output logic                           fifo_a2d_command_wr_en,
    output logic [CMD_W-1:0]               fifo_a2d_command_din,
    input  logic                           fifo_a2d_command_full,
    output logic                           cmd_other_valid,
    input  logic                           cmd_other_take,
    output logic [NUM_WORDS*PAYLOAD_W-1:0] cfg_flat,
    output logic                           cfg_valid,
    output logic [IDX_W-1:0]               cfg_ptr,
    output logic                           cfg_error
);

    logic [OPCODE_W-1:0]              cmd_op_s;
    logic [CMD_PL_W-1:0]              cmd_pl_s;
    logic                             cmd_owned_s;
    logic                             pop_ok_s;
    logic                             rd_en_s;
    logic                             ptr_full_s;
    logic                             ptr_last_s;
    logic                             idx_ok_s;
    logic                             wr_commit_s;
    logic                             slot_can_accept_s;
    logic                             slot_load_s;
    logic [CMD_W-1:0]                 slot_data_s;
    logic [PAYLOAD_W-1:0]             rd_word_s;
    logic [NUM_WORDS*PAYLOAD_W-1:0]   word_flat_s;

    logic [IDX_W-1:0]                 cfg_ptr_q, cfg_ptr_d;
    logic                             cfg_valid_q, cfg_valid_d;
    logic                             cfg_error_q, cfg_error_d;

    assign cmd_op_s   = fifo_d2a_command_dout[OPCODE_W-1:0];
    assign cmd_pl_s   = fifo_d2a_command_dout[CMD_W-1:OPCODE_W];
    assign ptr_full_s = (cfg_ptr_q == IDX_W'(NUM_WORDS));
    assign ptr_last_s = (cfg_ptr_q == IDX_W'(NUM_WORDS - 1));
    // Index check uses the full payload so large indices never alias.
    assign idx_ok_s   = (cmd_pl_s < CMD_PL_W'(NUM_WORDS));

    // Ownership decode of the head opcode.
    always_comb begin
        case (cmd_op_s)
            OP_WR, OP_SET_IDX, OP_RD, OP_CLEAR: cmd_owned_s = 1'b1;
            default:                            cmd_owned_s = 1'b0;
        endcase
    end

    assign cmd_other_valid = ~fifo_d2a_command_empty & ~cmd_owned_s;

    // Per-opcode pop permission. A WR that overflows produces no response,
    // so only an in-range WR waits for the response slot.
    always_comb begin
        case (cmd_op_s)
            OP_WR:               pop_ok_s = ptr_full_s | slot_can_accept_s;
            OP_SET_IDX, OP_CLEAR: pop_ok_s = 1'b1;
            OP_RD:               pop_ok_s = slot_can_accept_s;
            default:             pop_ok_s = cmd_other_take & cmd_other_valid;
        endcase
    end

    assign rd_en_s                = ~fifo_d2a_command_empty & pop_ok_s;
    assign fifo_d2a_command_rd_en = rd_en_s;

    // Readback mux; an out-of-range index matches no word and returns zero.
    always_comb begin
        rd_word_s = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (cmd_pl_s == CMD_PL_W'(i)) begin
                rd_word_s = word_flat_s[PAYLOAD_W*i +: PAYLOAD_W];
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Command execution: next pointer/flags and response slot load.
    always_comb begin
        cfg_ptr_d   = cfg_ptr_q;
        cfg_valid_d = cfg_valid_q;
        cfg_error_d = cfg_error_q;
        wr_commit_s = 1'b0;
        slot_load_s = 1'b0;
        slot_data_s = '0;
        if (rd_en_s) begin
            case (cmd_op_s)
                OP_WR: begin
                    if (!ptr_full_s) begin
                        wr_commit_s = 1'b1;
                        cfg_ptr_d   = cfg_ptr_q + IDX_W'(1);
                        if (ptr_last_s) begin
                            cfg_valid_d = 1'b1;
                            slot_load_s = 1'b1;
                            slot_data_s = build_resp('0, OP_ACK);
                        end else begin
                            cfg_valid_d = cfg_valid_q;
                        end
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
                OP_SET_IDX: begin
                    if (idx_ok_s) begin
                        cfg_ptr_d = cmd_pl_s[IDX_W-1:0];
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
                OP_RD: begin
                    slot_load_s = 1'b1;
                    slot_data_s = build_resp(CMD_PL_W'(rd_word_s), OP_RD_RSP);
                    if (idx_ok_s) begin
                        cfg_error_d = cfg_error_q;
                    end else begin
                        cfg_error_d = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    cfg_ptr_d   = '0;
                    cfg_valid_d = 1'b0;
                    cfg_error_d = 1'b0;
                end
                default: begin
                    cfg_ptr_d = cfg_ptr_q;
                end
            endcase
        end else begin
            cfg_ptr_d = cfg_ptr_q;
        end
    end

    // Pointer and status registers.
    always_ff @(posedge clk_a_domain) begin
        if (reset) begin
            cfg_ptr_q   <= '0;
            cfg_valid_q <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            cfg_ptr_q   <= cfg_ptr_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    // Storage: one register per word, write enable decoded from the pointer.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        logic                 we_s;
        logic [PAYLOAD_W-1:0] word_q;

        assign we_s = wr_commit_s & (cfg_ptr_q == IDX_W'(g));

        // Word register; CLEAR deliberately leaves contents untouched.
        always_ff @(posedge clk_a_domain) begin
            if (reset) begin
                word_q <= '0;
            end else if (we_s) begin
                word_q <= cmd_pl_s[PAYLOAD_W-1:0];
            end else begin
                word_q <= word_q;
            end
        end

        assign word_flat_s[PAYLOAD_W*g +: PAYLOAD_W] = word_q;
    end

    a_cfg_resp_slot u_resp_slot (
        .clk_i        (clk_a_domain),
        .reset_i      (reset),
        .load_i       (slot_load_s),
        .load_data_i  (slot_data_s),
        .full_i       (fifo_a2d_command_full),
        .can_accept_o (slot_can_accept_s),
        .wr_en_o      (fifo_a2d_command_wr_en),
        .din_o        (fifo_a2d_command_din)
    );

    assign cfg_flat  = word_flat_s;
    assign cfg_valid = cfg_valid_q;
    assign cfg_ptr   = cfg_ptr_q;
    assign cfg_error = cfg_error_q;

endmodule
